// File: rtl/jtkiwi_shr_pkg.sv
// Shared types for the Kiwi shared-RAM arbiter: per-port request state,
// port-select constants and the per-port next-state function.
package jtkiwi_shr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } shr_state_t;

  localparam logic MAIN = 1'b0;
  localparam logic SUB  = 1'b1;

  // Next state of one requester port. A grant is only ever issued while cs
  // is high and the port is not DONE, so IDLE+grant goes straight to DONE.
  function automatic shr_state_t shr_next(input shr_state_t st,
                                          input logic       cs,
                                          input logic       grant);
    shr_next = st;
    case (st)
      IDLE:    if (grant) shr_next = DONE; else if (cs) shr_next = PEND;
      PEND:    if (!cs) shr_next = IDLE; else if (grant) shr_next = DONE;
      DONE:    if (!cs) shr_next = IDLE;
      default: shr_next = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/jtkiwi_shr_ram.sv
// Single-port synchronous RAM, registered read (1-cycle latency).
// Ports: clk, we (write enable), addr, data (write data), q (read data).
module jtkiwi_shr_ram #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] q
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin : ram_port
    if (we) mem[addr] <= data;
    q <= mem[addr];
  end

endmodule

// File: rtl/jtkiwi_shrarb.sv
// Shared-RAM arbiter between the Kiwi main CPU and the sub CPU.
// Ports: clk, rstn (async, active-low); main_*/sub_* request (cs, rnw, addr,
// dout) and response (din, ack pulse, wait_n) per CPU; mshramen gates sub
// grants; st_dout is a registered debug snapshot of arbiter state.
module jtkiwi_shrarb
  import jtkiwi_shr_pkg::*;
#(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          main_cs,
  input  logic          main_rnw,
  input  logic [AW-1:0] main_addr,
  input  logic [DW-1:0] main_dout,
  output logic [DW-1:0] main_din,
  output logic          main_ack,
  output logic          main_wait_n,
  input  logic          sub_cs,
  input  logic          sub_rnw,
  input  logic [AW-1:0] sub_addr,
  input  logic [DW-1:0] sub_dout,
  output logic [DW-1:0] sub_din,
  output logic          sub_ack,
  output logic          sub_wait_n,
  input  logic          mshramen,
  output logic [7:0]    st_dout
);

  shr_state_t    st_main, st_sub, nx_main, nx_sub;
  logic          el_main, el_sub, gnt_main, gnt_sub;
  logic          last_grant;
  logic          rd_main, rd_sub;
  logic [DW-1:0] din_main_q, din_sub_q;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, ram_q;

  // Eligibility, round-robin grant, RAM port mux and per-port next state.
  always_comb begin : arb
    el_main  = main_cs & (st_main != DONE);
    el_sub   = sub_cs & mshramen & (st_sub != DONE);
    gnt_main = el_main & (~el_sub | (last_grant == SUB));
    gnt_sub  = el_sub & ~gnt_main;
    ram_addr = gnt_sub ? sub_addr : main_addr;
    ram_data = gnt_sub ? sub_dout : main_dout;
    ram_we   = (gnt_main & ~main_rnw) | (gnt_sub & ~sub_rnw);
    nx_main  = shr_next(st_main, main_cs, gnt_main);
    nx_sub   = shr_next(st_sub, sub_cs, gnt_sub);
  end

  // Port state, ack pulses, read-data holding registers and debug snapshot.
  always_ff @(posedge clk or negedge rstn) begin : regs
    if (!rstn) begin
      st_main    <= IDLE;
      st_sub     <= IDLE;
      main_ack   <= 1'b0;
      sub_ack    <= 1'b0;
      rd_main    <= 1'b0;
      rd_sub     <= 1'b0;
      din_main_q <= '0;
      din_sub_q  <= '0;
      last_grant <= SUB;
      st_dout    <= 8'h00;
    end else begin
      st_main  <= nx_main;
      st_sub   <= nx_sub;
      main_ack <= gnt_main;
      sub_ack  <= gnt_sub;
      rd_main  <= gnt_main & main_rnw;
      rd_sub   <= gnt_sub & sub_rnw;
      if (rd_main) din_main_q <= ram_q;
      if (rd_sub) din_sub_q <= ram_q;
      if (gnt_main | gnt_sub) last_grant <= gnt_sub ? SUB : MAIN;
      st_dout  <= {last_grant, 2'(st_main), 2'(st_sub), 3'b000};
    end
  end

  // The RAM output register is only meaningful in the read-ack cycle; the
  // holding register takes over from the next cycle on.
  assign main_din    = rd_main ? ram_q : din_main_q;
  assign sub_din     = rd_sub ? ram_q : din_sub_q;
  assign main_wait_n = ~(main_cs & (st_main != DONE) & ~main_ack);
  assign sub_wait_n  = ~(sub_cs & (st_sub != DONE) & ~sub_ack);

  jtkiwi_shr_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .data (ram_data),
    .q    (ram_q)
  );

endmodule

// File: tb/tb_jtkiwi_shrarb.sv
// Self-checking bench for jtkiwi_shrarb: directed table + corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_jtkiwi_shrarb;

  logic        clk, rstn;
  logic        main_cs, main_rnw, sub_cs, sub_rnw, mshramen;
  logic [12:0] main_addr, sub_addr;
  logic [7:0]  main_dout, sub_dout, main_din, sub_din, st_dout;
  logic        main_ack, main_wait_n, sub_ack, sub_wait_n;

  int n_total = 0;
  int n_pass  = 0;

  jtkiwi_shrarb dut (
    .clk(clk), .rstn(rstn),
    .main_cs(main_cs), .main_rnw(main_rnw), .main_addr(main_addr),
    .main_dout(main_dout), .main_din(main_din), .main_ack(main_ack),
    .main_wait_n(main_wait_n),
    .sub_cs(sub_cs), .sub_rnw(sub_rnw), .sub_addr(sub_addr),
    .sub_dout(sub_dout), .sub_din(sub_din), .sub_ack(sub_ack),
    .sub_wait_n(sub_wait_n),
    .mshramen(mshramen), .st_dout(st_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  typedef struct {
    bit          p;
    bit          rnw;
    logic [12:0] a;
    logic [7:0]  d;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl [10];

  // reference model state for the random phase
  bit         r_cs [2], r_rnw [2], served [2], acked [2];
  bit         gnt_prev [2], gnt_next [2], cur_ack [2], exp_wait [2], elig [2];
  logic [3:0] r_a [2];
  logic [7:0] r_d [2], rd_prev [2], rd_next [2], last_din [2];
  logic [7:0] mmem [16];
  int         hold [2];
  bit         last_win, win;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input bit p, input bit cs, input bit rnw,
                          input logic [12:0] a, input logic [7:0] d);
    if (p) begin sub_cs = cs; sub_rnw = rnw; sub_addr = a; sub_dout = d; end
    else begin main_cs = cs; main_rnw = rnw; main_addr = a; main_dout = d; end
  endtask

  task automatic set_cs(input bit p, input bit v);
    if (p) sub_cs = v; else main_cs = v;
  endtask

  function automatic logic ack_of(input bit p);
    return p ? sub_ack : main_ack;
  endfunction

  function automatic logic wait_of(input bit p);
    return p ? sub_wait_n : main_wait_n;
  endfunction

  function automatic logic [7:0] din_of(input bit p);
    return p ? sub_din : main_din;
  endfunction

  // Uncontended single access: ack one cycle after cs, wait_n low once.
  task automatic do_access(input bit p, input bit rnw, input logic [12:0] a,
                           input logic [7:0] d, input logic [7:0] exp, input string nm);
    set_port(p, 1'b1, rnw, a, d);
    @(negedge clk);
    check({nm, "_wait_req"}, 32'(wait_of(p)), 32'd0);
    check({nm, "_ack_req"}, 32'(ack_of(p)), 32'd0);
    step();
    @(negedge clk);
    check({nm, "_ack"}, 32'(ack_of(p)), 32'd1);
    check({nm, "_wait_ack"}, 32'(wait_of(p)), 32'd1);
    check({nm, "_din"}, 32'(din_of(p)), 32'(exp));
    step();
    set_cs(p, 1'b0);
    @(negedge clk);
    check({nm, "_ack_end"}, 32'(ack_of(p)), 32'd0);
    step();
  endtask

  // Simultaneous reads from both ports; 'first' is the expected winner.
  task automatic tie(input bit first, input string nm);
    set_port(1'b0, 1'b1, 1'b1, 13'h0123, 8'h00);
    set_port(1'b1, 1'b1, 1'b1, 13'h1FFF, 8'h00);
    @(negedge clk);
    check({nm, "_wait_m"}, 32'(main_wait_n), 32'd0);
    check({nm, "_wait_s"}, 32'(sub_wait_n), 32'd0);
    step();
    @(negedge clk);
    check({nm, "_ack_win"}, 32'(ack_of(first)), 32'd1);
    check({nm, "_ack_lose"}, 32'(ack_of(!first)), 32'd0);
    check({nm, "_wait_lose"}, 32'(wait_of(!first)), 32'd0);
    step();
    set_cs(first, 1'b0);
    @(negedge clk);
    check({nm, "_ack_lose2"}, 32'(ack_of(!first)), 32'd1);
    check({nm, "_ack_win2"}, 32'(ack_of(first)), 32'd0);
    check({nm, "_din_m"}, 32'(main_din), 32'h00A5);
    check({nm, "_din_s"}, 32'(sub_din), 32'h005A);
    step();
    set_cs(!first, 1'b0);
    @(negedge clk);
    check({nm, "_acks_end"}, 32'({main_ack, sub_ack}), 32'd0);
    step();
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 13'h0123, 8'hA5, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 13'h0123, 8'h00, 8'hA5};
    tbl[2] = '{1'b1, 1'b0, 13'h1FFF, 8'h5A, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 13'h1FFF, 8'h00, 8'h5A};
    tbl[4] = '{1'b0, 1'b0, 13'h0000, 8'h00, 8'hA5};
    tbl[5] = '{1'b1, 1'b0, 13'h0001, 8'hFF, 8'h5A};
    tbl[6] = '{1'b0, 1'b1, 13'h0001, 8'h00, 8'hFF};
    tbl[7] = '{1'b1, 1'b1, 13'h0000, 8'h00, 8'h00};
    tbl[8] = '{1'b0, 1'b1, 13'h1FFF, 8'h00, 8'h5A};
    tbl[9] = '{1'b1, 1'b1, 13'h0123, 8'h00, 8'hA5};

    rstn = 1'b1;
    set_port(1'b0, 1'b0, 1'b1, 13'h0, 8'h0);
    set_port(1'b1, 1'b0, 1'b1, 13'h0, 8'h0);
    mshramen = 1'b1;
    #1 rstn = 1'b0;
    #2;
    check("rst_acks", 32'({main_ack, sub_ack}), 32'd0);
    check("rst_dins", 32'({main_din, sub_din}), 32'd0);
    check("rst_waits", 32'({main_wait_n, sub_wait_n}), 32'd3);
    check("rst_st_dout", 32'(st_dout), 32'd0);
    #9 rstn = 1'b1;
    step();

    for (int i = 0; i < 10; i++)
      do_access(tbl[i].p, tbl[i].rnw, tbl[i].a, tbl[i].d, tbl[i].exp, $sformatf("tbl%0d", i));

    // round-robin: last grant was sub, so main wins; after a solo main, sub wins
    tie(1'b0, "tie1");
    do_access(1'b0, 1'b1, 13'h0123, 8'h00, 8'hA5, "rr_main");
    tie(1'b1, "tie2");

    // sub blocked by mshramen while main keeps being served
    mshramen = 1'b0;
    set_port(1'b1, 1'b1, 1'b1, 13'h1FFF, 8'h00);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) set_port(1'b0, 1'b1, 1'b1, 13'h0123, 8'h00);
      if (i == 7) set_cs(1'b0, 1'b0);
      @(negedge clk);
      check("gate_sub_wait", 32'(sub_wait_n), 32'd0);
      check("gate_sub_ack", 32'(sub_ack), 32'd0);
      if (i == 3) check("gate_st_dout", 32'(st_dout), 32'h08);
      if (i == 5) check("gate_main_wait", 32'(main_wait_n), 32'd0);
      if (i == 6) check("gate_main_ack", 32'(main_ack), 32'd1);
      if (i == 6) check("gate_main_din", 32'(main_din), 32'hA5);
      if (i == 7) check("gate_main_ack_end", 32'(main_ack), 32'd0);
      step();
    end
    mshramen = 1'b1;
    @(negedge clk);
    check("ungate_ack0", 32'(sub_ack), 32'd0);
    check("ungate_wait0", 32'(sub_wait_n), 32'd0);
    step();
    @(negedge clk);
    check("ungate_ack1", 32'(sub_ack), 32'd1);
    check("ungate_din", 32'(sub_din), 32'h5A);
    check("ungate_wait1", 32'(sub_wait_n), 32'd1);
    step();

    // cs held after ack is not a new request; a 1-cycle drop is
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("hold_no_ack", 32'(sub_ack), 32'd0);
      check("hold_wait", 32'(sub_wait_n), 32'd1);
      step();
    end
    set_cs(1'b1, 1'b0);
    @(negedge clk);
    check("drop_ack", 32'(sub_ack), 32'd0);
    step();
    set_cs(1'b1, 1'b1);
    @(negedge clk);
    check("rearm_ack0", 32'(sub_ack), 32'd0);
    check("rearm_wait0", 32'(sub_wait_n), 32'd0);
    step();
    @(negedge clk);
    check("rearm_ack1", 32'(sub_ack), 32'd1);
    step();
    @(negedge clk);
    check("rearm_ack2", 32'(sub_ack), 32'd0);
    step();
    set_cs(1'b1, 1'b0);
    step();

    // aborted pending write leaves RAM untouched
    mshramen = 1'b0;
    set_port(1'b1, 1'b1, 1'b0, 13'h0001, 8'h3C);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("abort_pend_ack", 32'(sub_ack), 32'd0);
      step();
    end
    set_cs(1'b1, 1'b0);
    mshramen = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("abort_no_ack", 32'(sub_ack), 32'd0);
      step();
    end
    do_access(1'b0, 1'b1, 13'h0001, 8'h00, 8'hFF, "abort_keep");

    // asynchronous reset in the middle of a pending sub request
    mshramen = 1'b0;
    set_port(1'b1, 1'b1, 1'b1, 13'h0123, 8'h00);
    step();
    #2 rstn = 1'b0;
    #1;
    check("mrst_acks", 32'({main_ack, sub_ack}), 32'd0);
    check("mrst_dins", 32'({main_din, sub_din}), 32'd0);
    check("mrst_sub_wait", 32'(sub_wait_n), 32'd0);
    check("mrst_main_wait", 32'(main_wait_n), 32'd1);
    check("mrst_st_dout", 32'(st_dout), 32'd0);
    set_cs(1'b1, 1'b0);
    #1;
    check("mrst_sub_wait_cs0", 32'(sub_wait_n), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    step();
    mshramen = 1'b1;
    do_access(1'b0, 1'b1, 13'h0123, 8'h00, 8'hA5, "mrst_ram_m");
    do_access(1'b1, 1'b1, 13'h1FFF, 8'h00, 8'h5A, "mrst_ram_s");

    // seed the random address window, then restart from reset
    for (int i = 0; i < 16; i++) begin
      mmem[i] = 8'($urandom);
      do_access(1'b0, 1'b0, {9'h010, 4'(i)}, mmem[i], 8'hA5, "seed");
    end
    #2 rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step();

    last_win = 1'b1;
    for (int p = 0; p < 2; p++) begin
      r_cs[p] = 0; r_rnw[p] = 1; served[p] = 0; acked[p] = 0; hold[p] = 0;
      gnt_prev[p] = 0; r_a[p] = 0; r_d[p] = 0; rd_prev[p] = 0; rd_next[p] = 0;
      last_din[p] = 8'h00;
    end

    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (r_cs[p] && acked[p]) begin
          if (hold[p] == 0) begin r_cs[p] = 0; served[p] = 0; acked[p] = 0; end
          else hold[p]--;
        end else if (!r_cs[p] && $urandom_range(0, 2) != 0) begin
          r_cs[p] = 1; r_rnw[p] = 1'($urandom); r_a[p] = 4'($urandom);
          r_d[p] = 8'($urandom); served[p] = 0; acked[p] = 0;
          hold[p] = int'($urandom_range(0, 3));
        end
        set_port(1'(p), r_cs[p], r_rnw[p], {9'h010, r_a[p]}, r_d[p]);
      end
      if ($urandom_range(0, 15) == 0) mshramen = ~mshramen;

      for (int p = 0; p < 2; p++) begin
        cur_ack[p] = gnt_prev[p];
        if (cur_ack[p]) begin
          acked[p] = 1;
          if (r_rnw[p]) last_din[p] = rd_prev[p];
        end
        exp_wait[p] = !(r_cs[p] && !served[p]);
        gnt_next[p] = 0;
      end

      // one access per cycle; a tie goes to whoever was not served last
      elig[0] = r_cs[0] && !served[0];
      elig[1] = r_cs[1] && !served[1] && mshramen;
      if (elig[0] || elig[1]) begin
        win = (elig[0] && elig[1]) ? !last_win : elig[1];
        last_win = win;
        served[win] = 1;
        gnt_next[win] = 1;
        if (r_rnw[win]) rd_next[win] = mmem[r_a[win]];
        else mmem[r_a[win]] = r_d[win];
      end

      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        check($sformatf("rnd_ack%0d_c%0d", p, c), 32'(ack_of(1'(p))), 32'(cur_ack[p]));
        check($sformatf("rnd_wait%0d_c%0d", p, c), 32'(wait_of(1'(p))), 32'(exp_wait[p]));
        check($sformatf("rnd_din%0d_c%0d", p, c), 32'(din_of(1'(p))), 32'(last_din[p]));
      end
      for (int p = 0; p < 2; p++) begin
        gnt_prev[p] = gnt_next[p];
        rd_prev[p]  = rd_next[p];
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
